// File: rtl/output_serializer.sv
// output_serializer
// Captures one snapshot of all PE results on a load pulse, then streams the
// words out one per beat on a valid/ready interface, with optional ReLU.
// out_valid/out_data/out_addr depend only on registered state, never on out_ready.
module output_serializer #(
    parameter int N     = 17,
    parameter int LANES = 32,
    parameter int AW    = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               relu_en,
    input  logic [LANES*N-1:0] pe_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [N-1:0]       out_data,
    output logic [AW-1:0]      out_addr,
    output logic               busy,
    output logic               done,
    output logic               load_err
);

    // state | meaning
    // IDLE  | waiting for load; stream idle
    // DRAIN | presenting bank[cnt_q] until the last lane transfers
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_LANE = AW'(LANES - 1);

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   bank_q [LANES];
    logic [AW-1:0]  cnt_q;
    logic           relu_q;
    logic           done_q;
    logic           load_err_q;
    logic           accept;
    logic           xfer;
    logic           last_xfer;
    logic [N-1:0]   word;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and stream control, decoded from registered state only
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                xfer      = out_ready;
                last_xfer = out_ready && (cnt_q == LAST_LANE);
                if (last_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Snapshot bank and ReLU mode; written only when a load is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= '0;
            end
            relu_q <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= pe_data[k*N +: N];
            end
            relu_q <= relu_en;
        end
    end

    // Lane counter: cleared on accept, advanced per transfer, parked at the last lane
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (xfer && !last_xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= last_xfer;
            load_err_q <= load && (state_q == DRAIN);
        end
    end

    // Output word with ReLU; address and data read as zero when not valid
    always_comb begin
        word     = bank_q[cnt_q];
        out_addr = out_valid ? cnt_q : '0;
        out_data = '0;
        if (out_valid && !(relu_q && word[N-1])) begin
            out_data = word;
        end
    end

    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: reset, drain, backpressure, ReLU,
// load collisions and reset mid-drain.
module tb_output_serializer;

    localparam int N     = 17;
    localparam int LANES = 32;
    localparam int AW    = 5;
    localparam int OW    = 4 + AW + N;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               load;
    logic               relu_en;
    logic [LANES*N-1:0] pe_data;
    logic               out_ready;
    logic               out_valid;
    logic [N-1:0]       out_data;
    logic [AW-1:0]      out_addr;
    logic               busy;
    logic               done;
    logic               load_err;

    int vectors = 0;
    int errors  = 0;

    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;

    always #5 clk = ~clk;

    assign obs = {out_valid, busy, done, load_err, out_addr, out_data};

    output_serializer #(.N(N), .LANES(LANES), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .relu_en   (relu_en),
        .pe_data   (pe_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .load_err  (load_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int base);
        for (int k = 0; k < LANES; k++) begin
            pe_data[k*N +: N] = N'(base + k);
        end
    endtask

    // Pulse load for one edge, then disturb the inputs to prove capture isolation
    task automatic do_load(input logic relu);
        relu_en = relu;
        load    = 1'b1;
        tick();
        load    = 1'b0;
        relu_en = ~relu;
        pe_data = ~pe_data;
    endtask

    task automatic test_reset;
        reset_n   = 1'b1;
        load      = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        set_lanes(1);
        tick();
        do_load(1'b0);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, {OW{1'b0}});
        end
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, {OW{1'b0}});
        end
    endtask

    task automatic test_basic_drain;
        set_lanes(1);
        out_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < LANES; i++) begin
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, AW'(i), N'(i + 1)};
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h want %h", i, obs, exp_v);
            end
            tick();
        end
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {N{1'b0}}};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL basic_done: got %h want %h", obs, exp_v);
        end
        tick();
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL basic_after_done: got %h want %h", obs, {OW{1'b0}});
        end
    endtask

    task automatic test_backpressure;
        set_lanes(1);
        out_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < LANES; i++) begin
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, AW'(i), N'(i + 1)};
            if (i == 7) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    vectors++;
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL bp_stall%0d: got %h want %h", s, obs, exp_v);
                    end
                    tick();
                end
                out_ready = 1'b1;
            end
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h want %h", i, obs, exp_v);
            end
            tick();
        end
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {N{1'b0}}};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL bp_done: got %h want %h", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_relu;
        logic [N-1:0] exp_w [LANES];
        for (int pass = 0; pass < 2; pass++) begin
            pe_data = '0;
            pe_data[0*N +: N] = 17'h1FFFF;
            pe_data[1*N +: N] = 17'h0FFFF;
            pe_data[2*N +: N] = 17'h10000;
            pe_data[3*N +: N] = 17'h00005;
            for (int k = 0; k < LANES; k++) exp_w[k] = '0;
            exp_w[1] = 17'h0FFFF;
            exp_w[3] = 17'h00005;
            if (pass == 1) begin
                exp_w[0] = 17'h1FFFF;
                exp_w[2] = 17'h10000;
            end
            out_ready = 1'b1;
            do_load(pass == 0);
            for (int i = 0; i < LANES; i++) begin
                exp_v = {1'b1, 1'b1, 1'b0, 1'b0, AW'(i), exp_w[i]};
                vectors++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL relu%0d_beat%0d: got %h want %h", pass, i, obs, exp_v);
                end
                tick();
            end
            tick();
        end
    endtask

    task automatic test_load_collision;
        set_lanes(1);
        out_ready = 1'b1;
        do_load(1'b0);
        for (int i = 0; i < LANES; i++) begin
            exp_v = {1'b1, 1'b1, 1'b0, (i == 13), AW'(i), N'(i + 1)};
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL coll_beat%0d: got %h want %h", i, obs, exp_v);
            end
            if (i == 12) begin
                set_lanes(500);
                load = 1'b1;
            end
            tick();
            load = 1'b0;
        end
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, {AW{1'b0}}, {N{1'b0}}};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL coll_done: got %h want %h", obs, exp_v);
        end
        set_lanes(100);
        load = 1'b1;
        tick();
        load = 1'b0;
        pe_data = ~pe_data;
        for (int i = 0; i < LANES; i++) begin
            exp_v = {1'b1, 1'b1, 1'b0, 1'b0, AW'(i), N'(100 + i)};
            vectors++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reload_beat%0d: got %h want %h", i, obs, exp_v);
            end
            if (i == LANES - 1) load = 1'b1;
            tick();
            load = 1'b0;
        end
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, {AW{1'b0}}, {N{1'b0}}};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL last_load_err: got %h want %h", obs, exp_v);
        end
        tick();
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL last_load_ignored: got %h want %h", obs, {OW{1'b0}});
        end
    endtask

    task automatic test_reset_mid_drain;
        set_lanes(1);
        out_ready = 1'b1;
        do_load(1'b0);
        repeat (10) tick();
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, AW'(10), N'(11)};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_pre: got %h want %h", obs, exp_v);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got %h want %h", obs, {OW{1'b0}});
        end
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL rst_mid_idle%0d: got %h want %h", c, obs, {OW{1'b0}});
            end
        end
        set_lanes(1);
        do_load(1'b0);
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, {AW{1'b0}}, N'(1)};
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_restart: got %h want %h", obs, exp_v);
        end
        repeat (LANES + 2) tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        load      = 1'b0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        pe_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_relu();
        test_load_collision();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Sits directly downstream of the 3-stage PE output delay buffer.
- On a load pulse it captures all 32 PE results of the 4x8 array (17-bit each) into a local bank.
- It then drains the bank one word per beat over a valid/ready stream towards the result writer/memory interface.
- Optional ReLU is applied per word on the way out.

Parameters:
- N, 17, width of one PE result (signed two's complement).
- LANES, 32, number of PE results captured per load (4 rows x 8 columns).
- AW, 5, width of the lane index / output address (ceil(log2(LANES))).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  capture request; accepted only in IDLE.
- relu_en  input  1  sampled with load; 1 = clamp negative words to 0 for this drain.
- pe_data  input  LANES*N  flattened PE results; lane k = (row-1)*8 + (col-1) at pe_data[k*N +: N] (pe11 = lane 0, pe48 = lane 31).
- out_ready  input  1  downstream ready.
- out_valid  output  1  out_data/out_addr hold a word.
- out_data  output  N  current word after optional ReLU.
- out_addr  output  AW  lane index of current word.
- busy  output  1  high while draining.
- done  output  1  one-cycle pulse after the last word transfers.
- load_err  output  1  one-cycle pulse when load arrives while busy.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low, named reset_n; the clock is clk.
- Reset: state=IDLE, bank=0, lane counter=0. Outputs out_valid, out_data, out_addr, busy, done, load_err = 0 immediately on reset assertion.
- States:
  - IDLE: out_valid=0, busy=0. load=1 -> capture all LANES words of pe_data and relu_en into registers, counter=0, go to DRAIN.
  - DRAIN: busy=1, out_valid=1, out_addr=counter, out_data=bank[counter] (ReLU applied).
    - A beat transfers when out_valid && out_ready; on transfer, counter increments.
    - Transfer at counter = LANES-1 -> IDLE next cycle, with done=1 for exactly that one cycle.
- Latency, load at edge t with out_ready held 1:
  - out_valid high for cycles t+1..t+32, out_addr 0..31 in order.
  - done high in cycle t+33, with busy=0 and out_valid=0.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_addr hold stable and the counter does not advance.
- No combinational path from out_ready to out_valid, out_data or out_addr. All three are driven from registers and the registered counter only.
- ReLU: when captured relu_en=1 and word MSB=1, out_data=0; otherwise out_data equals the bank word unchanged. No width change, no saturation.
- Capture isolation: changes on pe_data or relu_en after the load edge do not affect the drain in progress.
- load while in DRAIN, including the cycle of the final transfer:
  - The load is ignored; bank, counter and stream are unaffected.
  - load_err=1 on the following cycle, for one cycle.
- load in the done cycle: state is already IDLE, so the load is accepted normally. The next drain begins the cycle after; done and the new out_valid never overlap.
- Counter never wraps mid-drain; it returns to 0 only on a new accepted load or on reset.
- Reset asserted mid-drain: drain aborted, no done pulse. After release the block is in IDLE and awaits a new load; the next drain starts at lane 0.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> out_valid, busy, done, load_err, out_data, out_addr all 0 immediately; still 0 one cycle after release with load=0.
- Basic drain: lane k = k+1 (lane 0 = 17'd1 ... lane 31 = 17'd32), relu_en=0, out_ready=1, load at edge t -> 32 beats with out_addr 0..31 and out_data 1..32 in cycles t+1..t+32; done=1 only in t+33; busy=0 in t+33.
- Backpressure: same data; drop out_ready for 5 cycles while out_addr=7 -> out_data=17'd8 and out_addr=7 stable all 5 cycles; exactly 32 transfers total, no duplicates or skips; done one cycle after the lane-31 transfer.
- ReLU: lane 0 = 17'h1FFFF, lane 1 = 17'h0FFFF, lane 2 = 17'h10000.
  - relu_en=1 -> words 0x00000, 0x0FFFF, 0x00000.
  - Repeat with relu_en=0 -> 0x1FFFF, 0x0FFFF, 0x10000.
- Load collisions:
  - Pulse load at out_addr=12 -> load_err=1 for one cycle; stream continues 13..31 with the original data.
  - Pulse load in the done cycle with new data lane k = 100+k -> accepted; next stream starts with out_addr=0, out_data=17'd100.
- Reset mid-drain: assert reset_n=0 at out_addr=10 -> outputs 0 at once, no done pulse. Release, then load -> stream restarts at out_addr=0.
